// File: rtl/qpsk_pkg.sv
// -----------------------------------------------------------------------------
// Package: qpsk_pkg
// Purpose: Constants and helpers shared by the QPSK modulator and demodulator
//          blocks: default datapath widths, the QPSK bit-mapping constants
//          (sign of a rail -> hard bit) and the sat_clip saturation function.
// Contents:
//   QPSK_DATA_W  signed width of samples and NCO outputs
//   QPSK_SPS_W   width of the samples-per-symbol count
//   QPSK_ACC_W   accumulator width, sized so integration cannot overflow
//   QPSK_SHIFT   arithmetic right shift applied before output
//   QPSK_OUT_W   signed width of the soft symbol outputs
//   QPSK_BIT_POS / QPSK_BIT_NEG  hard bit for a non-negative / negative rail
//   sat_clip()   clamp an accumulator-width value to QPSK_OUT_W signed range
// -----------------------------------------------------------------------------
package qpsk_pkg;

    localparam int QPSK_DATA_W = 16;
    localparam int QPSK_SPS_W  = 8;
    localparam int QPSK_ACC_W  = 2 * QPSK_DATA_W + QPSK_SPS_W;
    localparam int QPSK_SHIFT  = 16;
    localparam int QPSK_OUT_W  = 16;

    // Zero decides as the non-negative symbol, matching the modulator mapper.
    localparam logic QPSK_BIT_POS = 1'b0;
    localparam logic QPSK_BIT_NEG = 1'b1;

    typedef struct packed {
        logic                         sat;
        logic signed [QPSK_OUT_W-1:0] val;
    } sat_res_t;

    // The value fits when every bit above the output sign bit equals the sign.
    function automatic sat_res_t sat_clip(input logic signed [QPSK_ACC_W-1:0] v);
        sat_res_t r;
        logic     pos_ovf;
        logic     neg_ovf;
        pos_ovf = !v[QPSK_ACC_W-1] &&  (|v[QPSK_ACC_W-2:QPSK_OUT_W-1]);
        neg_ovf =  v[QPSK_ACC_W-1] && !(&v[QPSK_ACC_W-2:QPSK_OUT_W-1]);
        r.sat   = pos_ovf || neg_ovf;
        if (pos_ovf) begin
            r.val = {1'b0, {(QPSK_OUT_W-1){1'b1}}};
        end else if (neg_ovf) begin
            r.val = {1'b1, {(QPSK_OUT_W-1){1'b0}}};
        end else begin
            r.val = v[QPSK_OUT_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/iad_accum.sv
// -----------------------------------------------------------------------------
// Module: iad_accum
// Purpose: One rail (I or Q) of the integrate-and-dump. Accumulates mixer
//          products and presents the shifted, range-limited dump value for the
//          symbol that completes this cycle. The caller owns the sample counter
//          and registers the dump value into its outputs.
// Configuration macro: DEMOD_SAT_EN -- when defined the dump value is clamped to
//          the signed OUT_W range and dump_sat_o flags a clamp; when undefined
//          the low OUT_W bits are taken (wrap) and dump_sat_o is 0.
// Ports:
//   clk         in  system clock, rising edge
//   reset_n     in  asynchronous reset, active low
//   vld_p1_i    in  product valid this cycle
//   clear_i     in  discard the partial symbol before adding this product
//   dump_i      in  this product completes the symbol
//   prod_p1_i   in  signed mixer product (2*DATA_W)
//   dump_val_o  out signed dump value of (acc + prod) >>> SHIFT (OUT_W)
//   dump_sat_o  out dump value was clamped
// -----------------------------------------------------------------------------
module iad_accum
    import qpsk_pkg::*;
#(
    parameter int DATA_W = QPSK_DATA_W,
    parameter int ACC_W  = QPSK_ACC_W,
    parameter int SHIFT  = QPSK_SHIFT,
    parameter int OUT_W  = QPSK_OUT_W
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       vld_p1_i,
    input  logic                       clear_i,
    input  logic                       dump_i,
    input  logic signed [2*DATA_W-1:0] prod_p1_i,
    output logic signed [OUT_W-1:0]    dump_val_o,
    output logic                       dump_sat_o
);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] sum_p1;

    // A clear coincident with a product makes that product the first of the
    // new symbol, so the clear is applied before the add.
    always_comb begin
        acc_base = clear_i ? '0 : acc_q;
        sum_p1   = acc_base + ACC_W'(prod_p1_i);
        acc_d    = acc_base;
        if (vld_p1_i) begin
            acc_d = dump_i ? '0 : sum_p1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

`ifdef DEMOD_SAT_EN
    sat_res_t clip;

    always_comb begin
        clip       = sat_clip(sum_p1 >>> SHIFT);
        dump_val_o = clip.val;
        dump_sat_o = clip.sat;
    end
`else
    assign dump_val_o = OUT_W'(sum_p1 >>> SHIFT);
    assign dump_sat_o = 1'b0;
`endif

endmodule

// File: rtl/qpsk_iq_demod.sv
// -----------------------------------------------------------------------------
// Module: qpsk_iq_demod
// Purpose: QPSK receive mixer plus integrate-and-dump. Real samples are mixed
//          with the quadrature NCO to baseband (I = s*cos, Q = -s*sin), then
//          integrated over sym_len samples. Each completed symbol produces one
//          m_valid pulse with soft I/Q values and two hard bits. Latency from
//          the last sample's s_valid to m_valid is 2 cycles.
// Configuration macro: DEMOD_SAT_EN -- clamp outputs to the OUT_W range and
//          report clamps on m_sat; otherwise outputs wrap and m_sat is 0.
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous reset, active low
//   s_valid    in   input sample strobe
//   s_data     in   signed input sample (DATA_W)
//   nco_sin    in   signed NCO sine, aligned with s_data (DATA_W)
//   nco_cos    in   signed NCO cosine, aligned with s_data (DATA_W)
//   sym_len    in   samples per symbol, 0 treated as 1 (SPS_W)
//   sym_start  in   pulse: discard partial symbol and restart integration
//   m_valid    out  pulse: symbol outputs updated
//   m_i        out  signed in-phase result (OUT_W)
//   m_q        out  signed quadrature result (OUT_W)
//   m_bits     out  hard decision {I<0, Q<0}
//   m_sat      out  a rail was clamped on this symbol
// -----------------------------------------------------------------------------
module qpsk_iq_demod
    import qpsk_pkg::*;
#(
    parameter int DATA_W = QPSK_DATA_W,
    parameter int SPS_W  = QPSK_SPS_W,
    parameter int ACC_W  = 2 * DATA_W + SPS_W,
    parameter int SHIFT  = QPSK_SHIFT,
    parameter int OUT_W  = QPSK_OUT_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     s_valid,
    input  logic signed [DATA_W-1:0] s_data,
    input  logic signed [DATA_W-1:0] nco_sin,
    input  logic signed [DATA_W-1:0] nco_cos,
    input  logic [SPS_W-1:0]         sym_len,
    input  logic                     sym_start,
    output logic                     m_valid,
    output logic signed [OUT_W-1:0]  m_i,
    output logic signed [OUT_W-1:0]  m_q,
    output logic [1:0]               m_bits,
    output logic                     m_sat
);

    logic                       vld_p1_q;
    logic signed [2*DATA_W-1:0] prod_i_p1_q;
    logic signed [2*DATA_W-1:0] prod_q_p1_q;
    logic signed [2*DATA_W-1:0] prod_i_d;
    logic signed [2*DATA_W-1:0] prod_q_d;

    logic [SPS_W-1:0]           cnt_q;
    logic [SPS_W-1:0]           cnt_d;
    logic [SPS_W-1:0]           len_q;
    logic [SPS_W-1:0]           len_d;
    logic [SPS_W-1:0]           cnt_base;
    logic [SPS_W-1:0]           len_use;
    logic                       dump;

    logic signed [OUT_W-1:0]    val_i;
    logic signed [OUT_W-1:0]    val_q;
    logic                       sat_i;
    logic                       sat_q;

    logic                       m_valid_q;
    logic signed [OUT_W-1:0]    m_i_q;
    logic signed [OUT_W-1:0]    m_q_q;
    logic [1:0]                 m_bits_q;
    logic                       m_sat_q;

    // ---- Stage p1: mixer ----
    always_comb begin
        prod_i_d =   (2*DATA_W)'(s_data) * (2*DATA_W)'(nco_cos);
        prod_q_d = -((2*DATA_W)'(s_data) * (2*DATA_W)'(nco_sin));
    end

    // Products are only consumed under vld_p1_q, so they need no reset.
    always_ff @(posedge clk) begin
        if (s_valid) begin
            prod_i_p1_q <= prod_i_d;
            prod_q_p1_q <= prod_q_d;
        end
    end

    // ---- Stage p2: integrate / dump control ----
    // sym_start behaves as if the count were already zero, so a coincident
    // product opens the new symbol and latches the current sym_len.
    always_comb begin
        cnt_base = sym_start ? '0 : cnt_q;
        if (cnt_base == '0) begin
            len_use = (sym_len == '0) ? SPS_W'(1) : sym_len;
        end else begin
            len_use = len_q;
        end
        dump  = vld_p1_q && (cnt_base == len_use - SPS_W'(1));
        len_d = len_q;
        if (vld_p1_q && (cnt_base == '0)) begin
            len_d = len_use;
        end
        cnt_d = cnt_base;
        if (dump) begin
            cnt_d = '0;
        end else if (vld_p1_q) begin
            cnt_d = cnt_base + SPS_W'(1);
        end
    end

    iad_accum #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SHIFT  (SHIFT),
        .OUT_W  (OUT_W)
    ) u_acc_i (
        .clk        (clk),
        .reset_n    (reset_n),
        .vld_p1_i   (vld_p1_q),
        .clear_i    (sym_start),
        .dump_i     (dump),
        .prod_p1_i  (prod_i_p1_q),
        .dump_val_o (val_i),
        .dump_sat_o (sat_i)
    );

    iad_accum #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SHIFT  (SHIFT),
        .OUT_W  (OUT_W)
    ) u_acc_q (
        .clk        (clk),
        .reset_n    (reset_n),
        .vld_p1_i   (vld_p1_q),
        .clear_i    (sym_start),
        .dump_i     (dump),
        .prod_p1_i  (prod_q_p1_q),
        .dump_val_o (val_q),
        .dump_sat_o (sat_q)
    );

    // ---- Stage p3: symbol outputs (held between dumps) ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1_q  <= 1'b0;
            cnt_q     <= '0;
            len_q     <= '0;
            m_valid_q <= 1'b0;
            m_i_q     <= '0;
            m_q_q     <= '0;
            m_bits_q  <= '0;
            m_sat_q   <= 1'b0;
        end else begin
            vld_p1_q  <= s_valid;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            m_valid_q <= dump;
            if (dump) begin
                m_i_q    <= val_i;
                m_q_q    <= val_q;
                m_bits_q <= {val_i[OUT_W-1] ? QPSK_BIT_NEG : QPSK_BIT_POS,
                             val_q[OUT_W-1] ? QPSK_BIT_NEG : QPSK_BIT_POS};
                m_sat_q  <= sat_i | sat_q;
            end
        end
    end

    assign m_valid = m_valid_q;
    assign m_i     = m_i_q;
    assign m_q     = m_q_q;
    assign m_bits  = m_bits_q;
    assign m_sat   = m_sat_q;

endmodule

// File: tb/tb_qpsk_iq_demod.sv
module tb_qpsk_iq_demod;

    logic               clk;
    logic               reset_n;
    logic               s_valid;
    logic signed [15:0] s_data;
    logic signed [15:0] nco_sin;
    logic signed [15:0] nco_cos;
    logic [7:0]         sym_len;
    logic               sym_start;
    logic               m_valid;
    logic signed [15:0] m_i;
    logic signed [15:0] m_q;
    logic [1:0]         m_bits;
    logic               m_sat;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Observed symbols
    int         got_i[$];
    int         got_q[$];
    logic [1:0] got_bits[$];
    logic       got_sat[$];
    int         got_cyc[$];

    // Expected symbols from the reference model
    int ex_i[$];
    int ex_q[$];
    bit ex_sat[$];
    int ex_cyc[$];

    // Reference model state: sample awaiting integration, current symbol
    bit     md_pv;
    longint md_pi, md_pq;
    int     md_n, md_L;
    longint md_si, md_sq;

    qpsk_iq_demod dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .nco_sin   (nco_sin),
        .nco_cos   (nco_cos),
        .sym_len   (sym_len),
        .sym_start (sym_start),
        .m_valid   (m_valid),
        .m_i       (m_i),
        .m_q       (m_q),
        .m_bits    (m_bits),
        .m_sat     (m_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_valid === 1'b1) begin
            got_i.push_back(int'(m_i));
            got_q.push_back(int'(m_q));
            got_bits.push_back(m_bits);
            got_sat.push_back(m_sat);
            got_cyc.push_back(cyc);
        end
    end

    // Symbol sum -> output value: floor(sum / 2^16), then clamp or wrap to 16 bits.
    function automatic void exp_sym(input longint acc, output int v, output bit sat);
        longint s;
        s   = acc >>> 16;
        sat = 1'b0;
`ifdef DEMOD_SAT_EN
        if (s > 32767) begin
            s = 32767; sat = 1'b1;
        end else if (s < -32768) begin
            s = -32768; sat = 1'b1;
        end
`else
        s = s & 64'hFFFF;
        if (s >= 32768) s = s - 65536;
`endif
        v = int'(s);
    endfunction

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic clear_queues();
        got_i.delete(); got_q.delete(); got_bits.delete(); got_sat.delete(); got_cyc.delete();
        ex_i.delete(); ex_q.delete(); ex_sat.delete(); ex_cyc.delete();
    endtask

    task automatic model_reset();
        md_pv = 1'b0; md_n = 0; md_L = 1; md_si = 0; md_sq = 0;
    endtask

    // Drive one clock cycle of inputs and advance the model. The product of a
    // sample is integrated in the cycle after the sample, together with that
    // cycle's sym_start and sym_len; a completed symbol shows on m_valid one
    // cycle later.
    task automatic step(input bit v, input int d, input int c, input int s,
                        input bit st, input int len);
        int cnow, vi, vq;
        bit si, sq;
        s_valid = v; s_data = 16'(d); nco_cos = 16'(c); nco_sin = 16'(s);
        sym_start = st; sym_len = 8'(len);
        cnow = cyc;
        if (st) begin
            md_n = 0; md_si = 0; md_sq = 0;
        end
        if (md_pv) begin
            if (md_n == 0) md_L = (len == 0) ? 1 : len;
            md_si += md_pi; md_sq += md_pq; md_n++;
            if (md_n == md_L) begin
                exp_sym(md_si, vi, si);
                exp_sym(md_sq, vq, sq);
                ex_i.push_back(vi); ex_q.push_back(vq);
                ex_sat.push_back(si | sq); ex_cyc.push_back(cnow + 1);
                md_n = 0; md_si = 0; md_sq = 0;
            end
        end
        md_pv = v;
        md_pi = longint'(d) * c;
        md_pq = -(longint'(d) * s);
        @(posedge clk); #1;
        s_valid = 1'b0; sym_start = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
        n_cmp++; if (m_i !== 16'sd0) begin n_fail++; $display("FAIL rst_m_i: got %0d want 0", m_i); end
        n_cmp++; if (m_q !== 16'sd0) begin n_fail++; $display("FAIL rst_m_q: got %0d want 0", m_q); end
        n_cmp++; if (m_bits !== 2'b00) begin n_fail++; $display("FAIL rst_m_bits: got %b want 00", m_bits); end
        n_cmp++; if (m_sat !== 1'b0) begin n_fail++; $display("FAIL rst_m_sat: got %b want 0", m_sat); end
    endtask

    task automatic test_mix_basic();
        int t_last;
        // 16384 * 32767 * 4 = 32767 * 2^16 exactly
        clear_queues();
        for (int k = 0; k < 4; k++) begin
            t_last = cyc;
            step(1, 16384, 32767, 0, 0, 4);
        end
        repeat (3) step(0, 0, 0, 0, 0, 4);
        n_cmp++;
        if (got_i.size() != 1) begin
            n_fail++; $display("FAIL case1_count: got %0d symbols want 1", got_i.size());
        end else begin
            n_cmp++; if (got_i[0] !== 32767) begin n_fail++; $display("FAIL case1_i: got %0d want 32767", got_i[0]); end
            n_cmp++; if (got_q[0] !== 0) begin n_fail++; $display("FAIL case1_q: got %0d want 0", got_q[0]); end
            n_cmp++; if (got_bits[0] !== 2'b00) begin n_fail++; $display("FAIL case1_bits: got %b want 00", got_bits[0]); end
            n_cmp++; if (got_cyc[0] !== t_last + 2) begin n_fail++; $display("FAIL case1_latency: got cycle %0d want %0d", got_cyc[0], t_last + 2); end
        end
        clear_queues();
        for (int k = 0; k < 4; k++) step(1, -16384, 32767, 32767, 0, 4);
        repeat (3) step(0, 0, 0, 0, 0, 4);
        n_cmp++;
        if (got_i.size() != 1) begin
            n_fail++; $display("FAIL case2_count: got %0d symbols want 1", got_i.size());
        end else begin
            n_cmp++; if (got_i[0] !== -32767) begin n_fail++; $display("FAIL case2_i: got %0d want -32767", got_i[0]); end
            n_cmp++; if (got_q[0] !== 32767) begin n_fail++; $display("FAIL case2_q: got %0d want 32767", got_q[0]); end
            n_cmp++; if (got_bits[0] !== 2'b10) begin n_fail++; $display("FAIL case2_bits: got %b want 10", got_bits[0]); end
        end
    endtask

    task automatic test_saturation();
        int  want_i;
        bit  want_sat;
        logic [1:0] want_bits;
        // 32767^2 * 8 >>> 16 = 131064, outside the 16-bit range
`ifdef DEMOD_SAT_EN
        want_i = 32767; want_sat = 1'b1; want_bits = 2'b00;
`else
        want_i = -8; want_sat = 1'b0; want_bits = 2'b10;
`endif
        clear_queues();
        for (int k = 0; k < 8; k++) step(1, 32767, 32767, 0, 0, 8);
        repeat (3) step(0, 0, 0, 0, 0, 8);
        n_cmp++;
        if (got_i.size() != 1) begin
            n_fail++; $display("FAIL sat_count: got %0d symbols want 1", got_i.size());
        end else begin
            n_cmp++; if (got_i[0] !== want_i) begin n_fail++; $display("FAIL sat_i: got %0d want %0d", got_i[0], want_i); end
            n_cmp++; if (got_sat[0] !== want_sat) begin n_fail++; $display("FAIL sat_flag: got %b want %b", got_sat[0], want_sat); end
            n_cmp++; if (got_bits[0] !== want_bits) begin n_fail++; $display("FAIL sat_bits: got %b want %b", got_bits[0], want_bits); end
        end
    endtask

    task automatic test_sym_start();
        int wi, wq;
        bit ws;
        clear_queues();
        repeat (2) step(1, 20000, 30000, 5000, 0, 4);
        step(0, 0, 0, 0, 0, 4);
        step(0, 0, 0, 0, 1, 4);
        repeat (4) step(1, -12000, 25000, 9000, 0, 4);
        repeat (3) step(0, 0, 0, 0, 0, 4);
        exp_sym(4 * (longint'(-12000) * 25000), wi, ws);
        exp_sym(4 * (-(longint'(-12000) * 9000)), wq, ws);
        n_cmp++;
        if (got_i.size() != 1) begin
            n_fail++; $display("FAIL symstart_count: got %0d symbols want 1", got_i.size());
        end else begin
            n_cmp++; if (got_i[0] !== wi) begin n_fail++; $display("FAIL symstart_i: got %0d want %0d", got_i[0], wi); end
            n_cmp++; if (got_q[0] !== wq) begin n_fail++; $display("FAIL symstart_q: got %0d want %0d", got_q[0], wq); end
        end
    endtask

    task automatic test_gaps_len();
        logic [1:0] eb;
        clear_queues();
        // sym_len 0 acts as 1: each isolated sample is its own symbol
        for (int k = 0; k < 3; k++) begin
            step(1, 3000 * (k + 1), -20000, 15000, 0, 0);
            repeat (k + 1) step(0, 0, 0, 0, 0, 0);
        end
        repeat (2) step(0, 0, 0, 0, 0, 4);
        // sym_len drops to 2 after the symbol has latched 4
        repeat (2) step(1, 20000, 20000, -7000, 0, 4);
        repeat (4) step(1, 20000, 20000, -7000, 0, 2);
        repeat (3) step(0, 0, 0, 0, 0, 2);
        n_cmp++;
        if (got_i.size() != 5 || ex_i.size() != 5) begin
            n_fail++; $display("FAIL gaps_count: got %0d symbols want 5 (model %0d)", got_i.size(), ex_i.size());
        end
        for (int k = 0; k < got_i.size() && k < ex_i.size(); k++) begin
            eb = {ex_i[k] < 0, ex_q[k] < 0};
            n_cmp++;
            if (got_i[k] !== ex_i[k] || got_q[k] !== ex_q[k] || got_bits[k] !== eb ||
                got_sat[k] !== ex_sat[k] || got_cyc[k] !== ex_cyc[k]) begin
                n_fail++;
                $display("FAIL gaps_sym%0d: got i=%0d q=%0d bits=%b sat=%b cyc=%0d want i=%0d q=%0d bits=%b sat=%b cyc=%0d",
                         k, got_i[k], got_q[k], got_bits[k], got_sat[k], got_cyc[k],
                         ex_i[k], ex_q[k], eb, ex_sat[k], ex_cyc[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] eb;
        clear_queues();
        repeat (2) step(1, 25000, 31000, -31000, 0, 4);
        reset_n = 1'b0;
        #1;
        n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_m_valid: got %b want 0", m_valid); end
        n_cmp++; if (m_i !== 16'sd0) begin n_fail++; $display("FAIL midrst_m_i: got %0d want 0", m_i); end
        n_cmp++; if (m_q !== 16'sd0) begin n_fail++; $display("FAIL midrst_m_q: got %0d want 0", m_q); end
        n_cmp++; if (m_bits !== 2'b00) begin n_fail++; $display("FAIL midrst_m_bits: got %b want 00", m_bits); end
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (4) step(1, -9000, 14000, 22000, 0, 4);
        repeat (3) step(0, 0, 0, 0, 0, 4);
        n_cmp++;
        if (got_i.size() != 1 || ex_i.size() != 1) begin
            n_fail++; $display("FAIL midrst_count: got %0d symbols want 1 (model %0d)", got_i.size(), ex_i.size());
        end
        for (int k = 0; k < got_i.size() && k < ex_i.size(); k++) begin
            eb = {ex_i[k] < 0, ex_q[k] < 0};
            n_cmp++;
            if (got_i[k] !== ex_i[k] || got_q[k] !== ex_q[k] || got_bits[k] !== eb || got_cyc[k] !== ex_cyc[k]) begin
                n_fail++;
                $display("FAIL midrst_sym: got i=%0d q=%0d bits=%b cyc=%0d want i=%0d q=%0d bits=%b cyc=%0d",
                         got_i[k], got_q[k], got_bits[k], got_cyc[k], ex_i[k], ex_q[k], eb, ex_cyc[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] eb;
        clear_queues();
        for (int k = 0; k < 400; k++) begin
            step(($urandom % 4) != 0, rnd16(), rnd16(), rnd16(),
                 ($urandom % 12) == 0, int'($urandom_range(0, 5)));
        end
        repeat (3) step(0, 0, 0, 0, 0, 3);
        n_cmp++;
        if (got_i.size() != ex_i.size()) begin
            n_fail++; $display("FAIL rand_count: got %0d symbols want %0d", got_i.size(), ex_i.size());
        end
        for (int k = 0; k < got_i.size() && k < ex_i.size(); k++) begin
            eb = {ex_i[k] < 0, ex_q[k] < 0};
            n_cmp++;
            if (got_i[k] !== ex_i[k] || got_q[k] !== ex_q[k] || got_bits[k] !== eb ||
                got_sat[k] !== ex_sat[k] || got_cyc[k] !== ex_cyc[k]) begin
                n_fail++;
                $display("FAIL rand_sym%0d: got i=%0d q=%0d bits=%b sat=%b cyc=%0d want i=%0d q=%0d bits=%b sat=%b cyc=%0d",
                         k, got_i[k], got_q[k], got_bits[k], got_sat[k], got_cyc[k],
                         ex_i[k], ex_q[k], eb, ex_sat[k], ex_cyc[k]);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; s_valid = 1'b0; s_data = '0; nco_sin = '0; nco_cos = '0;
        sym_len = 8'd4; sym_start = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset_n = 1'b1;
        @(posedge clk); #1;
        test_mix_basic();
        test_saturation();
        test_sym_start();
        test_gaps_len();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
